// File: rtl/fir_out_formatter.sv
// Output formatter for the horizontal FIR stage: tags each accepted pixel
// with frame position markers (sof/eol/eof) and buffers it in a small FIFO
// toward the downstream consumer.
module fir_out_formatter #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_CNT   = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    input  logic [LINE_CNT-1:0]   h_size_i,
    input  logic [LINE_CNT-1:0]   v_size_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  sof_o,
    output logic                  eol_o,
    output logic                  eof_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 3;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [LINE_CNT-1:0]   x_q, x_d, y_q, y_d;
    logic [LINE_CNT-1:0]   h_lat_q, v_lat_q;
    logic [PW:0]           wr_ptr_q, rd_ptr_q;
    logic                  ovf_q;
    logic                  rdy_en_q;
    logic [EW-1:0]         mem_q [FIFO_DEPTH];

    logic                  full, empty, accept, pop;
    logic [LINE_CNT-1:0]   h_eff, v_eff, h_last, v_last;
    logic                  sof, eol, eof;
    logic [EW-1:0]         head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // rdy_en_q keeps ready_o low for the first cycle after reset.
    assign ready_o = ce_i && !full && rdy_en_q;
    assign accept  = ce_i && valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // Sizes follow the inputs until a frame starts, then stay frozen.
    assign h_eff  = (state_q == IDLE) ? h_size_i : h_lat_q;
    assign v_eff  = (state_q == IDLE) ? v_size_i : v_lat_q;
    assign h_last = (h_eff == '0) ? '0 : h_eff - LINE_CNT'(1);
    assign v_last = (v_eff == '0) ? '0 : v_eff - LINE_CNT'(1);

    assign sof = (x_q == '0) && (y_q == '0);
    assign eol = (x_q == h_last);
    assign eof = eol && (y_q == v_last);

    assign head    = mem_q[rd_ptr_q[PW-1:0]];
    assign valid_o = !empty;
    assign data_o  = valid_o ? head[DATA_WIDTH-1:0] : '0;
    assign sof_o   = valid_o && head[DATA_WIDTH];
    assign eol_o   = valid_o && head[DATA_WIDTH+1];
    assign eof_o   = valid_o && head[DATA_WIDTH+2];
    assign ovf_o   = ovf_q;
    assign busy_o  = (state_q == RUN) || !empty;

    // Frame FSM: enter RUN on a frame start that is not also the frame end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && sof && !eof) state_d = RUN;
            RUN:     if (accept && eof)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Raster position: x wraps at line end, y wraps at frame end.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (eol) begin
                x_d = '0;
                y_d = eof ? '0 : y_q + LINE_CNT'(1);
            end else begin
                x_d = x_q + LINE_CNT'(1);
            end
        end
    end

    // Control state; ce_i low flushes the frame and the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            h_lat_q  <= '0;
            v_lat_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else if (!ce_i) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (accept)
                wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            if (valid_i && full)
                ovf_q <= 1'b1;
            if (accept && state_q == IDLE) begin
                h_lat_q <= h_size_i;
                v_lat_q <= v_size_i;
            end
        end
    end

    // Ready enable comes up one cycle after reset is released.
    always_ff @(posedge clk) begin
        if (!rst_n)
            rdy_en_q <= 1'b0;
        else
            rdy_en_q <= 1'b1;
    end

    // FIFO storage of {eof, eol, sof, data}; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (accept)
            mem_q[wr_ptr_q[PW-1:0]] <= {eof, eol, sof, data_i};
    end

endmodule

// File: tb/tb_fir_out_formatter.sv
// Randomized and directed bench for fir_out_formatter against a frame-index
// based reference model with a queue standing in for the FIFO.
module tb_fir_out_formatter;

    localparam int DW = 8;
    localparam int LC = 12;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n, ce_i, valid_i, ready_i;
    logic [DW-1:0] data_i;
    logic [LC-1:0] h_size_i, v_size_i;
    logic          ready_o, valid_o, sof_o, eol_o, eof_o, ovf_o, busy_o;
    logic [DW-1:0] data_o;

    always #5 clk = ~clk;

    fir_out_formatter #(.DATA_WIDTH(DW), .LINE_CNT(LC), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .ce_i(ce_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .h_size_i(h_size_i), .v_size_i(v_size_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW+2:0] mq[$];
    int            idx;
    int            lat_h, lat_v;
    bit            m_ovf, m_rdy_en, m_rst_flag;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int eff(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    function automatic bit exp_ready();
        return ce_i && (mq.size() < D) && m_rdy_en;
    endfunction

    task automatic model_reset();
        mq.delete();
        idx        = 0;
        m_ovf      = 0;
        m_rdy_en   = 0;
        m_rst_flag = 1;
    endtask

    // One clock cycle: check outputs at negedge, then advance the model at posedge.
    task automatic step();
        bit            acc, pop, sof, eol, eof;
        int            hs, vs, x, y;
        logic [DW+2:0] w;
        @(negedge clk);
        check("ready_o", ready_o, exp_ready());
        check("valid_o", valid_o, mq.size() > 0);
        check("ovf_o",   ovf_o,   m_ovf);
        check("busy_o",  busy_o,  (idx != 0) || (mq.size() > 0));
        if (mq.size() > 0)
            check("head", {eof_o, eol_o, sof_o, data_o}, mq[0]);
        else if (m_rst_flag)
            check("rst_zero", {eof_o, eol_o, sof_o, data_o}, 0);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_rst_flag = 0;
            if (!ce_i) begin
                mq.delete();
                idx   = 0;
                m_ovf = 0;
            end else begin
                acc = valid_i && exp_ready();
                pop = (mq.size() > 0) && ready_i;
                if (valid_i && mq.size() == D)
                    m_ovf = 1;
                if (pop) begin
                    w = mq.pop_front();
                    $display("out data=%02h sof=%0b eol=%0b eof=%0b", w[DW-1:0], w[DW], w[DW+1], w[DW+2]);
                end
                if (acc) begin
                    hs = (idx == 0) ? eff(int'(h_size_i)) : lat_h;
                    vs = (idx == 0) ? eff(int'(v_size_i)) : lat_v;
                    if (idx == 0) begin
                        lat_h = hs;
                        lat_v = vs;
                    end
                    x   = idx % hs;
                    y   = idx / hs;
                    sof = (idx == 0);
                    eol = (x == hs - 1);
                    eof = eol && (y == vs - 1);
                    mq.push_back({eof, eol, sof, data_i});
                    idx = eof ? 0 : idx + 1;
                end
            end
            m_rdy_en = 1;
        end
        #1;
    endtask

    task automatic pix(input logic [DW-1:0] d);
        valid_i = 1'b1;
        data_i  = d;
        step();
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic flush();
        ce_i = 1'b0;
        idle(1);
        ce_i = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ce_i     = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_i   = '0;
        h_size_i = LC'(4);
        v_size_i = LC'(2);
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        idle(1);                       // reset-state outputs
        rst_n = 1'b1;
        idle(1);                       // ready held low one cycle after reset

        // 4x2 frame, streaming
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) pix(DW'(i));
        idle(3);

        // 1x1 frame
        h_size_i = LC'(1);
        v_size_i = LC'(1);
        pix(8'hAA);
        idle(3);

        // backpressure and overflow
        h_size_i = LC'(8);
        v_size_i = LC'(2);
        ready_i  = 1'b0;
        for (int i = 1; i <= 6; i++) pix(DW'(i));
        ready_i = 1'b1;
        idle(5);
        pix(8'h07);
        idle(2);
        flush();

        // ce abort mid-frame
        h_size_i = LC'(4);
        ready_i  = 1'b0;
        for (int i = 1; i <= 3; i++) pix(DW'(i));
        flush();
        idle(1);
        ready_i = 1'b1;
        pix(8'h09);
        idle(2);
        flush();

        // reset mid-frame with two entries
        ready_i = 1'b0;
        pix(8'h11);
        pix(8'h12);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) pix(DW'(8'h20 + i));
        idle(2);
        flush();

        // size change mid-frame is ignored
        for (int i = 1; i <= 2; i++) pix(DW'(i));
        h_size_i = LC'(2);
        for (int i = 3; i <= 8; i++) pix(DW'(i));
        idle(3);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            data_i  = DW'($urandom);
            ce_i    = ($urandom_range(0, 59) != 0);
            rst_n   = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) h_size_i = LC'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) v_size_i = LC'($urandom_range(0, 4));
            step();
        end
        rst_n   = 1'b1;
        ce_i    = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
